// File: rtl/uu_acmac_tx_ctrl_mem_arb_pkg.sv
// uu_acmac_tx_ctrl_mem_arb_pkg: shared widths, FSM states and requester indices for the TX control memory arbiter
package uu_acmac_tx_ctrl_mem_arb_pkg;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;
   localparam int REQ_HOST = 0;
   localparam int REQ_TXE = 1;
   typedef enum logic {IDLE, BURST} state_t;
endpackage

// File: rtl/uu_acmac_tx_ctrl_mem_arb_if.sv
// uu_acmac_tx_ctrl_mem_arb_if: requester burst ports plus TX control memory bus
interface uu_acmac_tx_ctrl_mem_arb_if
   import uu_acmac_tx_ctrl_mem_arb_pkg::*;
#(
   parameter int AW = ADDR_W,
   parameter int DW = DATA_W
) ();
   logic [1:0] req, wr, gnt, beat, done, rvalid;
   logic [AW-1:0] addr0, addr1, mem_addr;
   logic [7:0] len0, len1;
   logic [DW-1:0] wdata0, wdata1, rdata, mem_wdata, mem_rdata;
   logic mem_en, mem_wen;
   modport master (
      output req, wr, addr0, addr1, len0, len1, wdata0, wdata1, mem_rdata,
      input gnt, beat, done, rvalid, rdata, mem_en, mem_wen, mem_addr, mem_wdata
   );
   modport slave (
      input req, wr, addr0, addr1, len0, len1, wdata0, wdata1, mem_rdata,
      output gnt, beat, done, rvalid, rdata, mem_en, mem_wen, mem_addr, mem_wdata
   );
endinterface

// File: rtl/uu_acmac_tx_ctrl_mem_arb_rr_arb2.sv
// uu_acmac_rr_arb2: two-input round-robin picker; last owner starts at 1 so input 0 wins the first tie
module uu_acmac_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       load,
   output logic       pick
);
   logic last;
   always_comb pick = &req ? ~last : req[1];
   always_ff @(posedge clk)
      if (rst) last <= 1'b1;
      else if (load) last <= pick;
endmodule

// File: rtl/uu_acmac_tx_ctrl_mem_arb.sv
// uu_acmac_tx_ctrl_mem_arb: round-robin burst sequencer sharing the TX control memory between host and TX engine
module uu_acmac_tx_ctrl_mem_arb
   import uu_acmac_tx_ctrl_mem_arb_pkg::*;
(
   input logic clk,
   input logic rst,
   uu_acmac_tx_ctrl_mem_arb_if.slave bus
);
   state_t state;
   logic pick, load;
   logic [8:0] rem;
   logic [1:0] gnt, rvalid;
   logic mem_en, mem_wen;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0] len_sel;
   always_comb load = (state == IDLE) && |bus.req;
   always_comb len_sel = pick ? bus.len1 : bus.len0;
   uu_acmac_rr_arb2 u_arb (.clk(clk), .rst(rst), .req(bus.req), .load(load), .pick(pick));
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         gnt <= '0;
         mem_en <= 1'b0;
         mem_wen <= 1'b0;
         mem_addr <= '0;
         rem <= '0;
         rvalid <= '0;
      end else begin
         rvalid <= gnt & {2{mem_en & ~mem_wen}};
         if (state == IDLE) begin
            if (load) begin
               state <= BURST;
               gnt <= pick ? 2'b10 : 2'b01;
               mem_en <= 1'b1;
               mem_wen <= bus.wr[pick];
               mem_addr <= pick ? bus.addr1 : bus.addr0;
               rem <= (len_sel == 8'd0) ? 9'd256 : {1'b0, len_sel};
            end
         end else begin
            rem <= rem - 9'd1;
            mem_addr <= mem_addr + 1'b1;
            if (rem == 9'd1) begin
               state <= IDLE;
               gnt <= '0;
               mem_en <= 1'b0;
               mem_wen <= 1'b0;
            end
         end
      end
   end
   // gnt is only non-zero in BURST, so it doubles as the per-requester beat strobe
   always_comb begin
      bus.gnt = gnt;
      bus.beat = gnt;
      bus.done = gnt & {2{rem == 9'd1}};
      bus.rvalid = rvalid;
      bus.rdata = |rvalid ? bus.mem_rdata : '0;
      bus.mem_en = mem_en;
      bus.mem_wen = mem_wen;
      bus.mem_addr = mem_addr;
      bus.mem_wdata = gnt[1] ? bus.wdata1 : gnt[0] ? bus.wdata0 : '0;
   end
endmodule

// File: tb/tb_uu_acmac_tx_ctrl_mem_arb.sv
// tb_uu_acmac_tx_ctrl_mem_arb: directed bench with a behavioural single-port memory behind the arbiter
module tb_uu_acmac_tx_ctrl_mem_arb;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [7:0] mem [256];
   logic [7:0] wc0, wc1, a, last_addr;
   int checks = 0;
   int errors = 0;
   int n, dcyc;
   logic [1:0] tie_seq [7];
   logic [1:0] drop_seq [6];
   logic [1:0] rst_seq [3];
   always #5 clk = ~clk;
   uu_acmac_tx_ctrl_mem_arb_if bus ();
   uu_acmac_tx_ctrl_mem_arb dut (.clk(clk), .rst(rst), .bus(bus));
   always @(posedge clk) begin
      if (bus.mem_en && bus.mem_wen) mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_en && !bus.mem_wen) bus.mem_rdata <= mem[bus.mem_addr];
      wc0 <= bus.gnt[0] ? wc0 + 8'd1 : 8'd0;
      wc1 <= bus.gnt[1] ? wc1 + 8'd1 : 8'd0;
   end
   assign bus.wdata0 = 8'hA0 + wc0;
   assign bus.wdata1 = 8'hC0 + wc1;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   initial begin
      tie_seq = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01};
      drop_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10};
      rst_seq = '{2'b01, 2'b00, 2'b10};
      bus.req = 2'b00;
      bus.wr = 2'b00;
      bus.addr0 = 8'h00;
      bus.addr1 = 8'h00;
      bus.len0 = 8'd0;
      bus.len1 = 8'd0;
      repeat (2) @(negedge clk);
      chk("rst_gnt", bus.gnt, 2'b00);
      chk("rst_beat", bus.beat, 2'b00);
      chk("rst_done", bus.done, 2'b00);
      chk("rst_rvalid", bus.rvalid, 2'b00);
      chk("rst_rdata", bus.rdata, 8'h00);
      chk("rst_mem_en", bus.mem_en, 1'b0);
      chk("rst_mem_addr", bus.mem_addr, 8'h00);
      chk("rst_mem_wdata", bus.mem_wdata, 8'h00);
      // single write burst from requester 0
      rst = 1'b0;
      bus.req = 2'b01;
      bus.wr = 2'b01;
      bus.addr0 = 8'h10;
      bus.len0 = 8'd4;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0) bus.req = 2'b00;
         chk("wr_gnt", bus.gnt, 2'b01);
         chk("wr_beat", bus.beat, 2'b01);
         chk("wr_en", {bus.mem_en, bus.mem_wen}, 2'b11);
         chk("wr_addr", bus.mem_addr, 8'h10 + i);
         chk("wr_wdata", bus.mem_wdata, 8'hA0 + i);
         chk("wr_done", bus.done, (i == 3) ? 2'b01 : 2'b00);
      end
      @(negedge clk);
      chk("wr_idle_gnt", bus.gnt, 2'b00);
      chk("wr_idle_en", bus.mem_en, 1'b0);
      // read back the same four bytes
      bus.req = 2'b01;
      bus.wr = 2'b00;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 0) bus.req = 2'b00;
         if (i < 4) begin
            chk("rd_en", {bus.mem_en, bus.mem_wen}, 2'b10);
            chk("rd_addr", bus.mem_addr, 8'h10 + i);
            chk("rd_done", bus.done, (i == 3) ? 2'b01 : 2'b00);
         end
         if (i > 0) begin
            chk("rd_rvalid", bus.rvalid, 2'b01);
            chk("rd_rdata", bus.rdata, 8'hA0 + i - 1);
         end else chk("rd_rvalid0", bus.rvalid, 2'b00);
      end
      // tie from reset: 0, idle, 1, idle, 0
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.req = 2'b11;
      bus.addr0 = 8'h20;
      bus.addr1 = 8'h40;
      bus.len0 = 8'd2;
      bus.len1 = 8'd2;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         chk("tie_gnt", bus.gnt, tie_seq[i]);
         if (i == 3) chk("tie_addr1", bus.mem_addr, 8'h40);
         if (i == 4) chk("tie_done1", bus.done, 2'b10);
         if (i == 6) bus.req = 2'b00;
      end
      @(negedge clk);
      chk("tie_done0", bus.done, 2'b01);
      @(negedge clk);
      // address wrap
      bus.req = 2'b01;
      bus.wr = 2'b01;
      bus.addr0 = 8'hFE;
      bus.len0 = 8'd4;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0) bus.req = 2'b00;
         a = 8'hFE + i[7:0];
         chk("wrap_addr", bus.mem_addr, a);
      end
      @(negedge clk);
      // len = 0 means 256 beats
      bus.req = 2'b10;
      bus.wr = 2'b00;
      bus.addr1 = 8'h00;
      bus.len1 = 8'd0;
      n = 0;
      dcyc = 0;
      last_addr = 8'h00;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (c == 0) bus.req = 2'b00;
         if (bus.beat[1]) n++;
         if (bus.done[1]) begin
            dcyc = n;
            last_addr = bus.mem_addr;
         end
      end
      chk("len256_beats", n, 256);
      chk("len256_done_at", dcyc, 256);
      chk("len256_last_addr", last_addr, 8'hFF);
      // requester 0 drops req mid-burst while requester 1 waits
      bus.req = 2'b01;
      bus.wr = 2'b01;
      bus.addr0 = 8'h80;
      bus.len0 = 8'd4;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 0) begin
            bus.req = 2'b10;
            bus.addr1 = 8'h90;
            bus.len1 = 8'd2;
         end
         chk("drop_gnt", bus.gnt, drop_seq[i]);
         if (i == 5) begin
            chk("drop_addr1", bus.mem_addr, 8'h90);
            bus.req = 2'b00;
         end
      end
      repeat (2) @(negedge clk);
      // reset on beat 3 of an 8-beat read
      bus.req = 2'b01;
      bus.wr = 2'b00;
      bus.addr0 = 8'h30;
      bus.len0 = 8'd8;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (i == 0) bus.req = 2'b00;
         chk("rr_addr", bus.mem_addr, 8'h30 + i);
      end
      rst = 1'b1;
      @(negedge clk);
      chk("rr_mem_en", bus.mem_en, 1'b0);
      chk("rr_gnt", bus.gnt, 2'b00);
      chk("rr_beat", bus.beat, 2'b00);
      chk("rr_done", bus.done, 2'b00);
      chk("rr_rvalid", bus.rvalid, 2'b00);
      chk("rr_rdata", bus.rdata, 8'h00);
      chk("rr_mem_addr", bus.mem_addr, 8'h00);
      rst = 1'b0;
      bus.req = 2'b11;
      bus.len0 = 8'd1;
      bus.len1 = 8'd1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rr_tie_gnt", bus.gnt, rst_seq[i]);
         if (i == 0) chk("rr_tie_done", bus.done, 2'b01);
         if (i == 2) bus.req = 2'b00;
      end
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
